// File: rtl/pong_pkg.sv
// Shared encodings and constants for the Pong game-flow logic.
package pong_pkg;

    localparam int CLK_HZ = 25_175_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_1P   = 2'd1;
    localparam logic [1:0] MODE_2P   = 2'd2;

    // Counter width able to hold the larger of two delays; never below one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk_0,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/match_sequencer.sv
// Pong match controller: mode select, serve delay, rally scoring, game-over hold.
//   state     | meaning
//   ST_IDLE   | waiting for a start pulse, paddles centred
//   ST_SERVE  | serve delay running, ball held
//   ST_PLAY   | rally live, misses score points
//   ST_OVER   | winner displayed for the hold time
module match_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = CLK_HZ,
    parameter int OVER_DELAY  = 3 * CLK_HZ
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       start_1p,
    input  logic       start_2p,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       reset_game,
    output logic [1:0] mode_choice,
    output logic       serve,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] state,
    output logic       winner
);

    localparam int TW = timer_width(SERVE_DELAY, OVER_DELAY);
    localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_DELAY - 1);
    localparam logic [TW-1:0] OVER_LOAD  = TW'(OVER_DELAY - 1);
    localparam logic [3:0]    WIN_VAL    = 4'(WIN_SCORE);

    state_t        state_q, state_d;
    logic          reset_game_q, reset_game_d;
    logic [1:0]    mode_q, mode_d;
    logic          serve_q, serve_d;
    logic          dir_q, dir_d;
    logic [3:0]    p1_q, p1_d;
    logic [3:0]    p2_q, p2_d;
    logic          winner_q, winner_d;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;

    cycle_timer #(
        .W(TW)
    ) u_timer (
        .clk_0   (clk_0),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        serve_d  = 1'b0;
        dir_d    = dir_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        winner_d = winner_q;
        tmr_load = 1'b0;
        tmr_val  = SERVE_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (start_1p || start_2p) begin
                    state_d  = ST_SERVE;
                    mode_d   = start_1p ? MODE_1P : MODE_2P;
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    dir_d    = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tmr_expired) begin
                    serve_d = 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Simultaneous misses on both edges are treated as noise.
                if (miss_left ^ miss_right) begin
                    tmr_load = 1'b1;
                    if (miss_right) begin
                        p1_d     = p1_q + 4'd1;
                        dir_d    = 1'b1;
                        winner_d = 1'b0;
                    end else begin
                        p2_d     = p2_q + 4'd1;
                        dir_d    = 1'b0;
                        winner_d = 1'b1;
                    end
                    if ((p1_d == WIN_VAL) || (p2_d == WIN_VAL)) begin
                        state_d = ST_OVER;
                        tmr_val = OVER_LOAD;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                    mode_d  = MODE_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        reset_game_d = (state_d == ST_IDLE) || (state_d == ST_OVER);
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            reset_game_q <= 1'b1;
            mode_q       <= MODE_NONE;
            serve_q      <= 1'b0;
            dir_q        <= 1'b0;
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            reset_game_q <= reset_game_d;
            mode_q       <= mode_d;
            serve_q      <= serve_d;
            dir_q        <= dir_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            winner_q     <= winner_d;
        end
    end

    assign state       = state_q;
    assign reset_game  = reset_game_q;
    assign mode_choice = mode_q;
    assign serve       = serve_q;
    assign serve_dir   = dir_q;
    assign score_p1    = p1_q;
    assign score_p2    = p2_q;
    assign winner      = winner_q;

endmodule
